// File: rtl/memory_responder.sv
// memory_responder: DEPTH x DATA_WIDTH RAM serving the core's shared data bus, with a streaming boot loader.
// Define MEMORY_BOUNDS_CHECK_EN to drop out-of-range core accesses and raise a sticky addressError.
`ifndef READ
`define READ 1'b1
`endif
`ifndef WRITE
`define WRITE 1'b0
`endif

module memory_responder #(
  parameter int DEPTH         = 1024,
  parameter int ADDRESS_WIDTH = 18,
  parameter int DATA_WIDTH    = 18,
  parameter bit BOOT_LOAD     = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  inout  wire  [DATA_WIDTH-1:0]    memoryData,
  input  logic                     memoryEnable,
  input  logic                     memoryReadWrite,
  input  logic [ADDRESS_WIDTH-1:0] memoryAddress,
  input  logic                     loadValid,
  input  logic [DATA_WIDTH-1:0]    loadData,
  input  logic                     loadLast,
  output logic                     loadReady,
  output logic                     coreHold,
  output logic                     addressError
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {LOAD, RUN} stateType;

  stateType              state, nextState;
  logic [IDX_W-1:0]      loadPtr;
  logic [IDX_W-1:0]      idx;
  logic                  inRange;
  logic                  loadFire;
  logic                  coreWrite;
  logic                  readDrive;
  logic                  wrEn;
  logic [IDX_W-1:0]      wrIdx;
  logic [DATA_WIDTH-1:0] wrData;
  logic [DATA_WIDTH-1:0] readReg;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset) state <= BOOT_LOAD ? LOAD : RUN;
    else        state <= nextState;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    nextState = state;
    if (state == LOAD && loadFire && (loadLast || loadPtr == IDX_W'(DEPTH - 1)))
      nextState = RUN;
  end

  always_comb begin
    loadReady = (state == LOAD) && reset;
    coreHold  = (state == LOAD);
    readDrive = (state == RUN) && memoryEnable && (memoryReadWrite == `READ);
  end

  assign loadFire = loadValid && loadReady;
  assign idx      = memoryAddress[IDX_W-1:0];

`ifdef MEMORY_BOUNDS_CHECK_EN
  assign inRange = memoryAddress < ADDRESS_WIDTH'(DEPTH);

  always_ff @(posedge clk) begin
    if (!reset)
      addressError <= 1'b0;
    else if (state == RUN && memoryEnable && !inRange)
      addressError <= 1'b1;
  end
`else
  logic unusedAddrBits;
  assign unusedAddrBits = ^memoryAddress[ADDRESS_WIDTH-1:IDX_W];
  assign inRange        = 1'b1;
  assign addressError   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset)        loadPtr <= '0;
    else if (loadFire) loadPtr <= loadPtr + 1'b1;
  end

  // One shared write port: the loader owns it in LOAD, the core in RUN.
  assign coreWrite = (state == RUN) && memoryEnable && (memoryReadWrite == `WRITE) && inRange;
  assign wrEn      = reset && (loadFire || coreWrite);
  assign wrIdx     = (state == LOAD) ? loadPtr  : idx;
  assign wrData    = (state == LOAD) ? loadData : memoryData;

  // NOTE: the RAM array has no reset so it maps onto block RAM and keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrIdx] <= wrData;
  end

  // Read-first: readReg samples the pre-write word on the same edge as a write.
  always_ff @(posedge clk) begin
    if (!reset)
      readReg <= '0;
    else if (state == RUN)
      readReg <= inRange ? mem[idx] : '0;
  end

  assign memoryData = readDrive ? readReg : 'z;

endmodule

// File: tb/tb_memory_responder.sv
// Self-checking bench for memory_responder: table-driven RUN accesses plus boot, bounds and reset sequences.
`ifndef READ
`define READ 1'b1
`endif
`ifndef WRITE
`define WRITE 1'b0
`endif

module tb_memory_responder;

  logic        clk;
  logic        reset;
  wire  [17:0] memoryData;
  logic        memoryEnable;
  logic        memoryReadWrite;
  logic [17:0] memoryAddress;
  logic        loadValid;
  logic [17:0] loadData;
  logic        loadLast;
  logic        loadReady;
  logic        coreHold;
  logic        addressError;

  logic [17:0] tbBus;
  logic        tbBusEn;
  assign memoryData = tbBusEn ? tbBus : 'z;

  int nChecks = 0;
  int nFails  = 0;

  memory_responder dut (
    .clk             (clk),
    .reset           (reset),
    .memoryData      (memoryData),
    .memoryEnable    (memoryEnable),
    .memoryReadWrite (memoryReadWrite),
    .memoryAddress   (memoryAddress),
    .loadValid       (loadValid),
    .loadData        (loadData),
    .loadLast        (loadLast),
    .loadReady       (loadReady),
    .coreHold        (coreHold),
    .addressError    (addressError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // chk: 0 = no compare, 1 = bus must carry exp, 2 = bus must be released (tb pulls it to 0)
  typedef struct {
    logic        en;
    logic        rw;
    logic [17:0] addr;
    logic [17:0] wdata;
    int          chk;
    logic [17:0] exp;
  } vecT;

  vecT vecs [10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idleBus();
    memoryEnable = 1'b0;
    tbBusEn      = 1'b1;
    tbBus        = '0;
  endtask

  task automatic coreRead(input logic [17:0] addr);
    memoryEnable    = 1'b1;
    memoryReadWrite = `READ;
    memoryAddress   = addr;
    tbBusEn         = 1'b0;
  endtask

  task automatic coreWrite(input logic [17:0] addr, input logic [17:0] data);
    memoryEnable    = 1'b1;
    memoryReadWrite = `WRITE;
    memoryAddress   = addr;
    tbBusEn         = 1'b1;
    tbBus           = data;
  endtask

  task automatic loadWord(input logic [17:0] data, input logic last);
    loadValid = 1'b1;
    loadData  = data;
    loadLast  = last;
    step();
    loadValid = 1'b0;
    loadLast  = 1'b0;
  endtask

  initial begin
    reset           = 1'b0;
    memoryReadWrite = `READ;
    memoryAddress   = '0;
    loadValid       = 1'b0;
    loadData        = '0;
    loadLast        = 1'b0;
    idleBus();

    vecs[0] = '{1'b1, `READ,  18'd0,    18'd0,      1, 18'h00001};
    vecs[1] = '{1'b1, `READ,  18'd1,    18'd0,      1, 18'h00002};
    vecs[2] = '{1'b1, `READ,  18'd2,    18'd0,      1, 18'h3FFFF};
    vecs[3] = '{1'b1, `WRITE, 18'd10,   18'h2A5A5,  0, 18'h00000};
    vecs[4] = '{1'b1, `READ,  18'd10,   18'd0,      1, 18'h2A5A5};
    vecs[5] = '{1'b1, `READ,  18'd10,   18'd0,      1, 18'h2A5A5};
    vecs[6] = '{1'b0, `READ,  18'd10,   18'd0,      2, 18'h00000};
    vecs[7] = '{1'b1, `WRITE, 18'd1023, 18'h0ABCD,  0, 18'h00000};
    vecs[8] = '{1'b0, `WRITE, 18'd1023, 18'd0,      2, 18'h00000};
    vecs[9] = '{1'b1, `READ,  18'd1023, 18'd0,      1, 18'h0ABCD};

    // Boot load
    repeat (5) step();
    check("reset_loadReady", loadReady, 1'b0);
    check("reset_coreHold", coreHold, 1'b1);
    check("reset_addressError", addressError, 1'b0);
    reset = 1'b1;
    #1;
    check("load_loadReady", loadReady, 1'b1);
    loadWord(18'h00001, 1'b0);
    loadWord(18'h00002, 1'b0);
    check("load_mid_coreHold", coreHold, 1'b1);
    loadWord(18'h3FFFF, 1'b1);
    check("boot_done_coreHold", coreHold, 1'b0);
    check("boot_done_loadReady", loadReady, 1'b0);

    // Table-driven RUN accesses
    for (int i = 0; i < 10; i++) begin
      memoryEnable    = vecs[i].en;
      memoryReadWrite = vecs[i].rw;
      memoryAddress   = vecs[i].addr;
      if (vecs[i].en && vecs[i].rw == `WRITE) begin
        tbBusEn = 1'b1;
        tbBus   = vecs[i].wdata;
      end else if (vecs[i].chk == 2) begin
        tbBusEn = 1'b1;
        tbBus   = '0;
      end else begin
        tbBusEn = 1'b0;
      end
      step();
      if (vecs[i].chk != 0)
        check($sformatf("vec%0d_bus", i), memoryData, vecs[i].exp);
    end

    // Read-during-write: old word first, new word on the next cycle
    coreRead(18'd2);
    step();
    check("rdw_before", memoryData, 18'h3FFFF);
    coreWrite(18'd2, 18'h15555);
    step();
    coreRead(18'd2);
    #1;
    check("rdw_old", memoryData, 18'h3FFFF);
    step();
    check("rdw_new", memoryData, 18'h15555);

    // Out-of-range access at DEPTH
    coreWrite(18'd1024, 18'h12345);
    step();
    coreRead(18'd1024);
    step();
`ifdef MEMORY_BOUNDS_CHECK_EN
    check("oob_bus", memoryData, 18'h00000);
    check("oob_error", addressError, 1'b1);
    coreRead(18'd0);
    step();
    check("oob_mem0", memoryData, 18'h00001);
`else
    check("oob_bus", memoryData, 18'h12345);
    check("oob_error", addressError, 1'b0);
    coreRead(18'd0);
    step();
    check("oob_mem0", memoryData, 18'h12345);
`endif

    // Reset in the middle of a load
    idleBus();
    reset = 1'b0;
    step();
    step();
    check("rst2_loadReady", loadReady, 1'b0);
    check("rst2_coreHold", coreHold, 1'b1);
    reset = 1'b1;
    #1;
    check("rst2_load_loadReady", loadReady, 1'b1);
    loadWord(18'h11111, 1'b0);
    loadWord(18'h22222, 1'b0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    #1;
    check("rst3_addressError", addressError, 1'b0);
    check("rst3_coreHold", coreHold, 1'b1);
    loadWord(18'h33333, 1'b1);
    check("rst3_done_coreHold", coreHold, 1'b0);
    coreRead(18'd0);
    step();
    check("rst3_mem0", memoryData, 18'h33333);
    coreRead(18'd1);
    step();
    check("rst3_mem1", memoryData, 18'h22222);
    coreRead(18'd2);
    step();
    check("rst3_mem2", memoryData, 18'h15555);

    // Full-depth load without loadLast
    idleBus();
    reset = 1'b0;
    step();
    reset = 1'b1;
    #1;
    for (int i = 0; i < 1024; i++) begin
      loadValid = 1'b1;
      loadLast  = 1'b0;
      loadData  = 18'(i * 3 + 5);
      #1;
      if (i == 1023) begin
        check("full_last_loadReady", loadReady, 1'b1);
        check("full_last_coreHold", coreHold, 1'b1);
      end
      step();
    end
    // Load port stays active but must now be ignored
    loadData = '0;
    loadLast = 1'b1;
    check("full_done_loadReady", loadReady, 1'b0);
    check("full_done_coreHold", coreHold, 1'b0);
    coreRead(18'd1023);
    step();
    check("full_mem1023", memoryData, 18'h00C02);
    coreRead(18'd0);
    step();
    check("full_mem0", memoryData, 18'h00005);
    coreRead(18'd512);
    step();
    check("full_mem512", memoryData, 18'h00605);
    loadValid = 1'b0;
    loadLast  = 1'b0;
    idleBus();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
